// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory transfer engine: state encoding, mode values
// and default RAM geometry.
package mem_xfer_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 7;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COPY_RD = 3'd1,
    COPY_WR = 3'd2,
    FILL_WR = 3'd3,
    DONE    = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/mem_xfer_addr_ctr.sv
// Wrapping AW-bit address pointer with load and increment. Exposes the value the
// pointer will hold after the next edge so the caller can register it as an address.
module mem_xfer_addr_ctr
  import mem_xfer_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] ptr_nxt
);

  logic [AW-1:0] ptr;

  always_comb begin
    ptr_nxt = ptr;
    if (load)
      ptr_nxt = load_val;
    else if (inc)
      ptr_nxt = ptr + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else
      ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mem_xfer_engine.sv
// Block COPY/FILL sequencer driving the 64x8 synchronous RAM port.
// Optional running byte checksum output enabled by `define XFER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start; len=0 start pulses done without leaving IDLE
// COPY_RD | present src address, RAM read in flight
// COPY_WR | write read byte to dst, advance src/dst, count down
// FILL_WR | write latched fill value to dst, advance dst, count down
// DONE    | one-cycle done pulse, then IDLE
module mem_xfer_engine
  import mem_xfer_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef XFER_CHECKSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  localparam logic [LW-1:0] LEN_MAX = LW'(2**AW);

  xfer_state_e   state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] din_q, din_nxt;
  logic [AW-1:0] addr_nxt, src_nxt, dst_nxt;
  logic          busy_nxt, done_nxt, wr_nxt;
  logic          accept, src_inc, dst_inc;
  logic [LW-1:0] len_clamp;

  assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
  assign accept    = (state == IDLE) && start && (len != '0);
  assign src_inc   = (state == COPY_WR);
  assign dst_inc   = (state == COPY_WR) || (state == FILL_WR);

  mem_xfer_addr_ctr #(.AW(AW)) u_src_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .inc      (src_inc),
    .load_val (src_addr),
    .ptr_nxt  (src_nxt)
  );

  mem_xfer_addr_ctr #(.AW(AW)) u_dst_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .inc      (dst_inc),
    .load_val (dst_addr),
    .ptr_nxt  (dst_nxt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    din_nxt   = din_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_nxt = 1'b1;
          end else begin
            cnt_nxt   = len_clamp;
            state_nxt = (mode == MODE_FILL) ? FILL_WR : COPY_RD;
            if (mode == MODE_FILL)
              din_nxt = fill_val;
          end
        end
      end
      COPY_RD: state_nxt = COPY_WR;
      COPY_WR: begin
        cnt_nxt   = cnt - 1'b1;
        state_nxt = (cnt == LW'(1)) ? DONE : COPY_RD;
      end
      FILL_WR: begin
        cnt_nxt   = cnt - 1'b1;
        state_nxt = (cnt == LW'(1)) ? DONE : FILL_WR;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == DONE)
      done_nxt = 1'b1;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    busy_nxt = (state_nxt == COPY_RD) || (state_nxt == COPY_WR) || (state_nxt == FILL_WR);
    wr_nxt   = (state_nxt == COPY_WR) || (state_nxt == FILL_WR);
    addr_nxt = mem_addr;
    case (state_nxt)
      COPY_RD:          addr_nxt = src_nxt;
      COPY_WR, FILL_WR: addr_nxt = dst_nxt;
      default:          addr_nxt = mem_addr;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      din_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      din_q    <= din_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      mem_wr   <= wr_nxt;
      mem_addr <= addr_nxt;
    end
  end

  // Copy data bypasses the register: the RAM's read data arrives in the write cycle itself.
  assign mem_din = (state == COPY_WR) ? mem_dout : din_q;

`ifdef XFER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum <= '0;
    else if ((state == IDLE) && start)
      csum <= '0;
    else if (mem_wr)
      csum <= csum + mem_din;
  end
`endif

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Scoreboard bench for mem_xfer_engine paired with a behavioural 64x8 synchronous RAM.
// Covers checksum output when built with `define XFER_CHECKSUM_EN.
module tb_mem_xfer_engine;
  import mem_xfer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [5:0] src_addr = '0;
  logic [5:0] dst_addr = '0;
  logic [6:0] len = '0;
  logic [7:0] fill_val = '0;
  logic       busy, done, mem_wr;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = '0;
`ifdef XFER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  mem_xfer_engine #(.AW(6), .DW(8), .LW(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .fill_val (fill_val),
    .busy     (busy),
    .done     (done),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
`ifdef XFER_CHECKSUM_EN
    ,
    .csum     (csum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    else        mem_dout <= ram[mem_addr];
  end

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb_q[$];
  wr_t        mon_e;
  logic [7:0] pmem [64];   // image after all planned writes
  logic [7:0] mmem [64];   // image after writes actually observed
  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && mem_wr) begin
      if (sb_q.size() == 0) begin
        check("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(mem_din), 32'(mon_e.data));
        mmem[mon_e.addr] = mon_e.data;
      end
    end
  end

  task automatic poke(input int a, input logic [7:0] v);
    ram[a] = v; pmem[a] = v; mmem[a] = v;
  endtask

  // Forward byte-by-byte reference: each COPY read sees earlier writes of the same command.
  task automatic plan(input logic m, input logic [5:0] s, input logic [5:0] d,
                      input logic [6:0] l, input logic [7:0] f);
    int n;
    logic [5:0] sp, dp;
    logic [7:0] b;
    n = (l > 7'd64) ? 64 : int'(l);
    sp = s; dp = d;
    for (int i = 0; i < n; i++) begin
      b = (m == MODE_FILL) ? f : pmem[sp];
      pmem[dp] = b;
      sb_q.push_back('{addr: dp, data: b});
      sp = sp + 6'd1;
      dp = dp + 6'd1;
    end
  endtask

  task automatic issue(input logic m, input logic [5:0] s, input logic [5:0] d,
                       input logic [6:0] l, input logic [7:0] f, input bit hold);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
    plan(m, s, d, l, f);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    // later input changes must not disturb the running command
    mode = ~m; src_addr = 6'($urandom); dst_addr = 6'($urandom);
    len = 7'($urandom); fill_val = 8'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic m, input logic [5:0] s,
                         input logic [5:0] d, input logic [6:0] l, input logic [7:0] f);
    int n, exp_lat, c;
    n = (l > 7'd64) ? 64 : int'(l);
    exp_lat = (m == MODE_FILL) ? n + 1 : 2 * n + 1;
    issue(m, s, d, l, f, 1'b0);
    wait_done(c);
    check({tag, "_lat"}, 32'(c), 32'(exp_lat));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic cmp_image(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mmem[i]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int bad, c, dc;
    for (int i = 0; i < 64; i++) poke(i, 8'(i * 7 + 3));
    #3 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd("fill64", MODE_FILL, 6'd0, 6'd0, 7'd64, 8'hA5);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== 8'hA5) bad++;
    check("fill64_all_a5", 32'(bad), 32'd0);

    poke(60, 8'h11); poke(61, 8'h22); poke(62, 8'h33); poke(63, 8'h44);
    run_cmd("copy_60_2", MODE_COPY, 6'd60, 6'd2, 7'd4, 8'h00);
    for (int i = 0; i < 4; i++) check("copy_60_2_byte", 32'(ram[2 + i]), 32'(8'h11 * (i + 1)));
    run_cmd("copy_src_wrap", MODE_COPY, 6'd62, 6'd0, 7'd4, 8'h00);
    cmp_image("copy_src_wrap_img");

    poke(0, 8'h5A);
    run_cmd("overlap", MODE_COPY, 6'd0, 6'd1, 7'd8, 8'h00);
    bad = 0;
    for (int i = 1; i <= 8; i++) if (ram[i] !== 8'h5A) bad++;
    check("overlap_replicate", 32'(bad), 32'd0);

    run_cmd("fill_dst_wrap", MODE_FILL, 6'd0, 6'd62, 7'd3, 8'h3C);
    cmp_image("fill_dst_wrap_img");
    run_cmd("copy_dst_wrap", MODE_COPY, 6'd10, 6'd61, 7'd5, 8'h00);
    cmp_image("copy_dst_wrap_img");
    run_cmd("fill_clamp", MODE_FILL, 6'd5, 6'd5, 7'd100, 8'h77);
    cmp_image("fill_clamp_img");
    for (int i = 0; i < 64; i++) poke(i, 8'(i * 13 + 1));

    // zero-length command: immediate done, no RAM traffic
    @(negedge clk);
    mode = MODE_FILL; len = 7'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_wr", 32'(mem_wr), 32'd0);
    @(negedge clk);
    check("len0_done_one_cycle", 32'(done), 32'd0);

    // start held high: one COPY runs, the next is accepted only once IDLE is reached
    issue(MODE_COPY, 6'd10, 6'd30, 7'd3, 8'h00, 1'b1);
    mode = MODE_COPY; src_addr = 6'd10; dst_addr = 6'd30; len = 7'd3;
    wait_done(c);
    check("held_lat", 32'(c), 32'd7);
    plan(MODE_COPY, 6'd10, 6'd30, 7'd3, 8'h00);
    @(negedge clk);
    check("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(c);
    check("held_lat2", 32'(c), 32'd6);   // one cycle of the second command already elapsed
    check("held_sb_drained", 32'(sb_q.size()), 32'd0);
    cmp_image("held_img");

    for (int k = 0; k < 5; k++)
      run_cmd("rand", 1'($urandom), 6'($urandom), 6'($urandom),
              7'($urandom_range(1, 12)), 8'($urandom));
    cmp_image("rand_img");

`ifdef XFER_CHECKSUM_EN
    run_cmd("cs_fill80", MODE_FILL, 6'd0, 6'd0, 7'd4, 8'h80);
    check("csum_fill80", 32'(csum), 32'h00);
    run_cmd("cs_fill21", MODE_FILL, 6'd0, 6'd40, 7'd4, 8'h21);
    check("csum_fill21", 32'(csum), 32'h84);
    poke(10, 8'h01); poke(11, 8'h02); poke(12, 8'h03);
    run_cmd("cs_copy", MODE_COPY, 6'd10, 6'd20, 7'd3, 8'h00);
    check("csum_copy", 32'(csum), 32'h06);
    repeat (3) @(negedge clk);
    check("csum_hold", 32'(csum), 32'h06);
`endif

    // reset during a 64-byte FILL after ten bytes
    for (int i = 0; i < 64; i++) poke(i, 8'(i) ^ 8'h3C);
    dc = done_cnt;
    issue(MODE_FILL, 6'd0, 6'd0, 7'd64, 8'hC3, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_wr", 32'(mem_wr), 32'd0);
    check("rstmid_pending", 32'(sb_q.size()), 32'd54);
    sb_q.delete();
    for (int i = 0; i < 64; i++) pmem[i] = mmem[i];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_no_done", 32'(done_cnt - dc), 32'd0);
    check("rstmid_byte9", 32'(ram[9]), 32'hC3);
    check("rstmid_byte10", 32'(ram[10]), 32'(8'd10 ^ 8'h3C));
    cmp_image("rstmid_img");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
